// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared types, metric codes and neighbour tables for the distance-transform engine
package dt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_RD,
        ST_INIT_WR,
        ST_FW_C,
        ST_FW_NB,
        ST_FW_WR,
        ST_BW_C,
        ST_BW_NB,
        ST_BW_WR,
        ST_DONE
    } dt_state_e;

    localparam logic METRIC_CHESS = 1'b0;
    localparam logic METRIC_CITY  = 1'b1;

    // Offset encoding: 0, +1, -1 (two's complement in two bits)
    localparam logic [1:0] OFF_Z = 2'b00;
    localparam logic [1:0] OFF_P = 2'b01;
    localparam logic [1:0] OFF_M = 2'b11;

    typedef struct packed {
        logic [1:0] dr;
        logic [1:0] dc;
    } nbr_off_t;

    // Ordered neighbour lists: FW chess NW,N,NE,W / city N,W; BW chess E,SW,S,SE / city E,S
    function automatic nbr_off_t nbr_off(input logic bw, input logic metric, input logic [1:0] k);
        nbr_off_t o;
        o.dr = OFF_Z;
        o.dc = OFF_Z;
        case ({bw, metric, k})
            4'b0000: begin o.dr = OFF_M; o.dc = OFF_M; end
            4'b0001: begin o.dr = OFF_M; o.dc = OFF_Z; end
            4'b0010: begin o.dr = OFF_M; o.dc = OFF_P; end
            4'b0011: begin o.dr = OFF_Z; o.dc = OFF_M; end
            4'b0100: begin o.dr = OFF_M; o.dc = OFF_Z; end
            4'b0101: begin o.dr = OFF_Z; o.dc = OFF_M; end
            4'b1000: begin o.dr = OFF_Z; o.dc = OFF_P; end
            4'b1001: begin o.dr = OFF_P; o.dc = OFF_M; end
            4'b1010: begin o.dr = OFF_P; o.dc = OFF_Z; end
            4'b1011: begin o.dr = OFF_P; o.dc = OFF_P; end
            4'b1100: begin o.dr = OFF_Z; o.dc = OFF_P; end
            4'b1101: begin o.dr = OFF_P; o.dc = OFF_Z; end
            default: begin o.dr = OFF_Z; o.dc = OFF_Z; end
        endcase
        return o;
    endfunction

    function automatic logic [1:0] nbr_last(input logic metric);
        return (metric == METRIC_CITY) ? 2'd1 : 2'd3;
    endfunction

    function automatic int dt_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/dt_nbr_min.sv
// rtl/dt_nbr_min.sv - running minimum over streamed neighbour values with saturating +1
module dt_nbr_min
    import dt_pkg::*;
#(
    parameter int DIST_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DIST_W-1:0] val,
    output logic [DIST_W:0]   min,
    output logic [DIST_W:0]   sat_inc
);

    localparam logic [DIST_W:0] SAT = {1'b0, {DIST_W{1'b1}}};

    logic [DIST_W:0] min_q;
    logic [DIST_W:0] min_d;
    logic [DIST_W:0] val_x;

    always_comb begin
        val_x = {1'b0, val};
        min_d = min_q;
        if (clr) begin
            min_d = '1;
        end else if (en && (val_x < min_q)) begin
            min_d = val_x;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= '1;
        end else begin
            min_q <= min_d;
        end
    end

    assign min     = min_q;
    // A cleared (all-ones) accumulator must not wrap to zero
    assign sat_inc = (min_q >= SAT) ? SAT : (min_q + 1'b1);

endmodule

// File: rtl/dt_engine_param.sv
// rtl/dt_engine_param.sv - parametrised two-pass chessboard/city-block distance-transform engine
module dt_engine_param
    import dt_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int STI_W  = 16,
    parameter int DIST_W = 8,
    parameter int SA_W   = dt_clog2(IMG_W * IMG_H / STI_W),
    parameter int RA_W   = dt_clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              metric,
    output logic              busy,
    output logic              fwpass_finish,
    output logic              done,
    output logic              sti_rd,
    output logic [SA_W-1:0]   sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RA_W-1:0]   res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);

    localparam int RW = dt_clog2(IMG_H);
    localparam int CW = dt_clog2(IMG_W);
    localparam int SB = dt_clog2(STI_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [SB-1:0] BIT_LAST = SB'(STI_W - 1);

    dt_state_e         state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [1:0]        k_q, k_d;
    logic [STI_W-1:0]  sti_q, sti_d;
    logic [DIST_W-1:0] c_q, c_d;
    logic              metric_q, metric_d;
    logic              fwfin_q, fwfin_d;
    logic              done_q, done_d;
    logic              armed_q;

    logic              fw_step, bw_step;
    logic              fw_last, bw_last;
    logic [RA_W-1:0]   pix_addr;

    nbr_off_t          off;
    logic [RW-1:0]     nrow;
    logic [CW-1:0]     ncol;
    logic              nbr_in;

    logic              acc_clr, acc_en;
    logic [DIST_W-1:0] acc_val;
    logic [DIST_W:0]   acc_min, acc_inc;
    logic [DIST_W-1:0] inc_sat;

    dt_nbr_min #(.DIST_W(DIST_W)) u_nbr_min (
        .clk     (clk),
        .reset   (reset),
        .clr     (acc_clr),
        .en      (acc_en),
        .val     (acc_val),
        .min     (acc_min),
        .sat_inc (acc_inc)
    );

    assign pix_addr = {row_q, col_q};
    assign fw_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign bw_last  = (row_q == '0) && (col_q == '0);
    assign inc_sat  = acc_inc[DIST_W] ? '1 : acc_inc[DIST_W-1:0];

    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign fwpass_finish = fwfin_q;
    assign done          = done_q;

    // Edge neighbours are flagged out-of-image before any wrapped address could be used
    always_comb begin
        off    = nbr_off(state_q == ST_BW_NB, metric_q, k_q);
        nrow   = row_q;
        ncol   = col_q;
        nbr_in = 1'b1;
        case (off.dr)
            OFF_P: begin nrow = row_q + 1'b1; if (row_q == ROW_LAST) nbr_in = 1'b0; end
            OFF_M: begin nrow = row_q - 1'b1; if (row_q == '0) nbr_in = 1'b0; end
            default: nrow = row_q;
        endcase
        case (off.dc)
            OFF_P: begin ncol = col_q + 1'b1; if (col_q == COL_LAST) nbr_in = 1'b0; end
            OFF_M: begin ncol = col_q - 1'b1; if (col_q == '0) nbr_in = 1'b0; end
            default: ncol = col_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        sti_d    = sti_q;
        c_d      = c_q;
        metric_d = metric_q;
        fwfin_d  = fwfin_q;
        done_d   = done_q;
        fw_step  = 1'b0;
        bw_step  = 1'b0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        acc_val  = '0;
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_rd   = 1'b0;
        res_wr   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && armed_q) begin
                    state_d  = ST_INIT_RD;
                    metric_d = metric;
                    fwfin_d  = 1'b0;
                    done_d   = 1'b0;
                    row_d    = '0;
                    col_d    = '0;
                end
            end
            ST_INIT_RD: begin
                sti_rd   = 1'b1;
                sti_addr = SA_W'(pix_addr >> SB);
                sti_d    = sti_di;
                state_d  = ST_INIT_WR;
            end
            ST_INIT_WR: begin
                res_wr   = 1'b1;
                res_addr = pix_addr;
                res_do   = DIST_W'(sti_q[STI_W-1]);
                sti_d    = sti_q << 1;
                if (fw_last) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_FW_C;
                end else begin
                    col_d = col_q + 1'b1;
                    if (col_q == COL_LAST) row_d = row_q + 1'b1;
                    if (col_q[SB-1:0] == BIT_LAST) state_d = ST_INIT_RD;
                end
            end
            ST_FW_C, ST_BW_C: begin
                res_rd   = 1'b1;
                res_addr = pix_addr;
                if (res_di == '0) begin
                    fw_step = (state_q == ST_FW_C);
                    bw_step = (state_q == ST_BW_C);
                end else begin
                    c_d     = res_di;
                    acc_clr = 1'b1;
                    k_d     = 2'd0;
                    state_d = (state_q == ST_FW_C) ? ST_FW_NB : ST_BW_NB;
                end
            end
            ST_FW_NB, ST_BW_NB: begin
                if (nbr_in) begin
                    res_rd   = 1'b1;
                    res_addr = {nrow, ncol};
                end
                acc_en  = 1'b1;
                acc_val = nbr_in ? res_di : '0;
                if (k_q == nbr_last(metric_q)) begin
                    state_d = (state_q == ST_FW_NB) ? ST_FW_WR : ST_BW_WR;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_FW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix_addr;
                res_do   = inc_sat;
                fw_step  = 1'b1;
            end
            ST_BW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix_addr;
                // c <= min is the same test as c < sat(min+1), without the extra adder
                res_do   = ({1'b0, c_q} <= acc_min) ? c_q : inc_sat;
                bw_step  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fw_step) begin
            if (fw_last) begin
                fwfin_d = 1'b1;
                row_d   = ROW_LAST;
                col_d   = COL_LAST;
                state_d = ST_BW_C;
            end else begin
                col_d = col_q + 1'b1;
                if (col_q == COL_LAST) row_d = row_q + 1'b1;
                state_d = ST_FW_C;
            end
        end
        if (bw_step) begin
            if (bw_last) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                col_d = col_q - 1'b1;
                if (col_q == '0) row_d = row_q - 1'b1;
                state_d = ST_BW_C;
            end
        end
    end

    // armed_q blocks a start seen on the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            sti_q    <= '0;
            c_q      <= '0;
            metric_q <= METRIC_CHESS;
            fwfin_q  <= 1'b0;
            done_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            sti_q    <= sti_d;
            c_q      <= c_d;
            metric_q <= metric_d;
            fwfin_q  <= fwfin_d;
            done_q   <= done_d;
            armed_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dt_engine_param.sv
// tb/tb_dt_engine_param.sv - directed self-checking bench for dt_engine_param (32x32 geometry)
module tb_dt_engine_param;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int SW    = 8;
    localparam int N     = W * H;
    localparam int NWD   = N / SW;
    localparam int SAW   = 7;
    localparam int RAW   = 10;
    localparam int BOUND = N * 14 + NWD + 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, metric_a, start_b, metric_b;
    logic busy_a, fwf_a, done_a, sti_rd_a, res_rd_a, res_wr_a;
    logic busy_b, fwf_b, done_b, sti_rd_b, res_rd_b, res_wr_b;
    logic [SAW-1:0] sti_addr_a, sti_addr_b;
    logic [SW-1:0]  sti_di_a, sti_di_b;
    logic [RAW-1:0] res_addr_a, res_addr_b;
    logic [7:0]     res_do_a, res_di_a;
    logic [1:0]     res_do_b, res_di_b;

    dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(8)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .metric(metric_a),
        .busy(busy_a), .fwpass_finish(fwf_a), .done(done_a),
        .sti_rd(sti_rd_a), .sti_addr(sti_addr_a), .sti_di(sti_di_a),
        .res_rd(res_rd_a), .res_wr(res_wr_a), .res_addr(res_addr_a),
        .res_do(res_do_a), .res_di(res_di_a)
    );

    dt_engine_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start_b), .metric(metric_b),
        .busy(busy_b), .fwpass_finish(fwf_b), .done(done_b),
        .sti_rd(sti_rd_b), .sti_addr(sti_addr_b), .sti_di(sti_di_b),
        .res_rd(res_rd_b), .res_wr(res_wr_b), .res_addr(res_addr_b),
        .res_do(res_do_b), .res_di(res_di_b)
    );

    bit         img    [N];
    logic [7:0] ram_a  [N];
    logic [1:0] ram_b  [N];
    int         fwexp  [N];
    int         n_checks = 0;
    int         n_errors = 0;
    bit         proto_err = 1'b0;

    typedef struct {
        int    img_id;
        bit    m;
        bit    sel;
        int    r;
        int    c;
        int    exp_v;
        string name;
    } vec_t;
    vec_t vecs [17];

    function automatic logic [SW-1:0] rom_word(input int w);
        logic [SW-1:0] r;
        for (int j = 0; j < SW; j++) r[SW-1-j] = img[w*SW + j];
        return r;
    endfunction

    always @(negedge clk) begin
        if (sti_rd_a) sti_di_a <= rom_word(int'(sti_addr_a));
        if (sti_rd_b) sti_di_b <= rom_word(int'(sti_addr_b));
        if (res_rd_a) res_di_a <= ram_a[res_addr_a];
        if (res_rd_b) res_di_b <= ram_b[res_addr_b];
        if ((res_rd_a && res_wr_a) || (res_rd_b && res_wr_b)) proto_err <= 1'b1;
    end

    always @(posedge clk) begin
        if (res_wr_a) ram_a[res_addr_a] <= res_do_a;
        if (res_wr_b) ram_b[res_addr_b] <= res_do_b;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic build_img(input int id);
        for (int p = 0; p < N; p++) img[p] = 1'b0;
        case (id)
            1: img[5*W + 5] = 1'b1;
            2: begin
                for (int r = 10; r <= 20; r++) for (int c = 10; c <= 20; c++) img[r*W + c] = 1'b1;
                img[15*W + 15] = 1'b0;
            end
            3: for (int r = 20; r <= 28; r++) for (int c = 20; c <= 28; c++) img[r*W + c] = 1'b1;
            4: begin
                for (int r = 2; r <= 12; r++) for (int c = 3; c <= 28; c++) img[r*W + c] = 1'b1;
                for (int r = 16; r <= 30; r++) for (int c = 2; c <= 2 + r - 16; c++) img[r*W + c] = 1'b1;
                for (int r = 14; r <= 31; r++) for (int c = 29; c <= 31; c++) img[r*W + c] = 1'b1;
                img[7*W + 10] = 1'b0;
            end
            default: ;
        endcase
    endtask

    function automatic int ram_get(input bit sel, input int p);
        return sel ? int'(ram_b[p]) : int'(ram_a[p]);
    endfunction

    // True distance to the nearest zero, the image border counting as zero
    function automatic int exp_dist(input int r, input int c, input bit m, input int maxv);
        int d, dr, dc, dd;
        if (!img[r*W + c]) return 0;
        d = r + 1;
        if (c + 1 < d) d = c + 1;
        if (H - r < d) d = H - r;
        if (W - c < d) d = W - c;
        for (int rr = 0; rr < H; rr++) begin
            for (int cc = 0; cc < W; cc++) begin
                if (!img[rr*W + cc]) begin
                    dr = (rr > r) ? rr - r : r - rr;
                    dc = (cc > c) ? cc - c : c - cc;
                    dd = m ? dr + dc : ((dr > dc) ? dr : dc);
                    if (dd < d) d = dd;
                end
            end
        end
        return (d > maxv) ? maxv : d;
    endfunction

    function automatic int full_mismatch(input bit sel, input bit m);
        int bad;
        bad = 0;
        for (int p = 0; p < N; p++)
            if (ram_get(sel, p) != exp_dist(p / W, p % W, m, sel ? 3 : 255)) bad++;
        return bad;
    endfunction

    function automatic int fw_mismatch(input bit m, input int maxv);
        int mn, v, bad;
        bad = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (!img[r*W + c]) begin
                    fwexp[r*W + c] = 0;
                end else begin
                    mn = 1 << 20;
                    for (int dr = -1; dr <= 0; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            if (!(dr == 0 && dc >= 0) && !(m && dr != 0 && dc != 0)) begin
                                if (r + dr < 0 || c + dc < 0 || c + dc >= W) v = 0;
                                else v = fwexp[(r+dr)*W + c + dc];
                                if (v < mn) mn = v;
                            end
                        end
                    end
                    fwexp[r*W + c] = (mn + 1 > maxv) ? maxv : mn + 1;
                end
                if (ram_get(1'b0, r*W + c) != fwexp[r*W + c]) bad++;
            end
        end
        return bad;
    endfunction

    task automatic do_run(input bit sel, input bit m, input bit chk_fw, input int mid_pulse, input string tag);
        int cyc;
        bit fw_seen;
        @(negedge clk);
        if (sel) begin metric_b = m; start_b = 1'b1; end
        else     begin metric_a = m; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, " busy after start"}, int'(sel ? busy_b : busy_a), 1);
        check({tag, " flags cleared"}, int'(sel ? {done_b, fwf_b} : {done_a, fwf_a}), 0);
        cyc = 1;
        fw_seen = 1'b0;
        while (!(sel ? done_b : done_a) && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (cyc == mid_pulse) begin start_a = 1'b1; metric_a = ~m; end
            if (cyc == mid_pulse + 1) start_a = 1'b0;
            if (chk_fw && !fw_seen && (sel ? fwf_b : fwf_a)) begin
                fw_seen = 1'b1;
                check({tag, " ram after forward pass"}, fw_mismatch(m, 255), 0);
            end
        end
        check({tag, " done within bound"}, int'(sel ? done_b : done_a), 1);
        check({tag, " busy low with done"}, int'(sel ? busy_b : busy_a), 0);
        if (chk_fw) check({tag, " fwpass_finish seen"}, int'(fw_seen), 1);
    endtask

    initial begin
        int cur, key, p;
        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; metric_a = 1'b0; metric_b = 1'b0;

        vecs[0]  = '{1, 1'b0, 1'b0, 5, 5, 1, "T2 single pixel"};
        vecs[1]  = '{1, 1'b0, 1'b0, 5, 6, 0, "T2 right of pixel"};
        vecs[2]  = '{1, 1'b0, 1'b0, 0, 0, 0, "T2 corner 0"};
        vecs[3]  = '{1, 1'b0, 1'b0, 31, 31, 0, "T2 last addr"};
        vecs[4]  = '{2, 1'b0, 1'b0, 14, 14, 1, "T3 chess diag of hole"};
        vecs[5]  = '{2, 1'b0, 1'b0, 15, 14, 1, "T3 chess beside hole"};
        vecs[6]  = '{2, 1'b0, 1'b0, 12, 12, 3, "T3 chess interior"};
        vecs[7]  = '{2, 1'b0, 1'b0, 15, 15, 0, "T3 chess hole"};
        vecs[8]  = '{2, 1'b0, 1'b0, 10, 10, 1, "T3 chess corner"};
        vecs[9]  = '{2, 1'b1, 1'b0, 14, 14, 2, "T3 city diag of hole"};
        vecs[10] = '{2, 1'b1, 1'b0, 12, 12, 3, "T3 city interior"};
        vecs[11] = '{2, 1'b1, 1'b0, 13, 15, 2, "T3 city above hole"};
        vecs[12] = '{2, 1'b1, 1'b0, 18, 18, 3, "T3 city lower interior"};
        vecs[13] = '{3, 1'b0, 1'b1, 24, 24, 3, "T4 saturated centre"};
        vecs[14] = '{3, 1'b0, 1'b1, 21, 21, 2, "T4 ring 2"};
        vecs[15] = '{3, 1'b0, 1'b1, 20, 24, 1, "T4 edge"};
        vecs[16] = '{3, 1'b0, 1'b1, 19, 24, 0, "T4 outside"};

        repeat (3) @(negedge clk);
        check("reset outputs A", int'({busy_a, fwf_a, done_a, sti_rd_a, sti_addr_a, res_rd_a, res_wr_a, res_addr_a, res_do_a}), 0);
        check("reset outputs B", int'({busy_b, fwf_b, done_b, sti_rd_b, sti_addr_b, res_rd_b, res_wr_b, res_addr_b, res_do_b}), 0);

        // start held across reset release must not be accepted
        build_img(4);
        reset = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("start at reset release ignored", int'(busy_a), 0);

        do_run(1'b0, 1'b0, 1'b1, -10, "T1");
        check("T1 final ram", full_mismatch(1'b0, 1'b0), 0);
        repeat (5) @(negedge clk);
        check("T1 done/fwpass_finish held", int'({done_a, fwf_a}), 3);

        cur = -1;
        for (int i = 0; i < 17; i++) begin
            key = vecs[i].img_id * 4 + int'(vecs[i].m) * 2 + int'(vecs[i].sel);
            if (key != cur) begin
                build_img(vecs[i].img_id);
                do_run(vecs[i].sel, vecs[i].m, 1'b0, -10, vecs[i].name);
                check({vecs[i].name, " full image"}, full_mismatch(vecs[i].sel, vecs[i].m), 0);
                cur = key;
            end
            p = vecs[i].r * W + vecs[i].c;
            check(vecs[i].name, ram_get(vecs[i].sel, p), vecs[i].exp_v);
        end

        // T5: asynchronous reset in the middle of the forward pass
        build_img(4);
        @(negedge clk);
        metric_a = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (N + NWD + 200) @(negedge clk);
        check("T5 mid forward pass", int'({busy_a, fwf_a}), 2);
        #2 reset = 1'b0;
        #1;
        check("T5 outputs zero in reset", int'({busy_a, fwf_a, done_a, sti_rd_a, sti_addr_a, res_rd_a, res_wr_a, res_addr_a, res_do_a}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_run(1'b0, 1'b0, 1'b1, -10, "T5 restart");
        check("T5 restart ram", full_mismatch(1'b0, 1'b0), 0);

        // T6: start while busy ignored; then restart with the other metric
        build_img(2);
        do_run(1'b0, 1'b0, 1'b0, 60, "T6 first");
        check("T6 first full image", full_mismatch(1'b0, 1'b0), 0);
        check("T6 metric kept", ram_get(1'b0, 14*W + 14), 1);
        do_run(1'b0, 1'b1, 1'b0, -10, "T6 second");
        check("T6 second full image", full_mismatch(1'b0, 1'b1), 0);
        check("T6 new metric", ram_get(1'b0, 14*W + 14), 2);

        check("rd/wr exclusive", int'(proto_err), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
